// File: rtl/riscv_io_ctrl.sv
// Memory-mapped UART/counter I/O block beside dmem; counters built only with RISCV_IO_COUNTERS_EN.
// Latency: io_dout registered 1 cycle after io_re; TX head is fall-through from storage.
// Backpressure: TX drains on uart_tx_valid&&uart_tx_ready; full-FIFO pushes drop and set sticky overflow.
module riscv_io_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    typedef logic [TXA:0] txp_t;
    typedef logic [RXA:0] rxp_t;

    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    txp_t       tx_wp, tx_rp;
    rxp_t       rx_wp, rx_rp;
    logic       tx_ovf, rx_ovf;

    logic       acc, rd, wr;
    logic [7:0] off;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_pop, tx_req, tx_push, tx_drop;
    logic       rx_pop, rx_push, rx_drop, stat_rd;
    logic [31:0] status, rd_val, cyc_rd, ins_rd;

    assign acc = io_addr[31] && !stall;
    assign off = io_addr[7:0];
    assign rd  = acc && io_re;
    assign wr  = acc && (io_we != 4'b0000);

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TXA-1:0] == tx_rp[TXA-1:0]) && (tx_wp[TXA] != tx_rp[TXA]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RXA-1:0] == rx_rp[RXA-1:0]) && (rx_wp[RXA] != rx_rp[RXA]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_pop  = !tx_empty && uart_tx_ready;
    assign tx_req  = wr && (off == 8'h08);
    assign tx_push = tx_req && (!tx_full || tx_pop);
    assign tx_drop = tx_req && tx_full && !tx_pop;

    assign rx_pop  = rd && (off == 8'h04) && !rx_empty;
    assign rx_push = uart_rx_valid && (!rx_full || rx_pop);
    assign rx_drop = uart_rx_valid && rx_full && !rx_pop;
    assign stat_rd = rd && (off == 8'h00);

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[TXA-1:0]];
    assign uart_rx_ready = 1'b1;

    assign status = {28'b0, rx_ovf, tx_ovf, !rx_empty, !tx_full};

    always_comb begin
        rd_val = 32'h0;
        case (off)
            8'h00: rd_val = status;
            8'h04: rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp[RXA-1:0]]};
            8'h10: rd_val = cyc_rd;
            8'h14: rd_val = ins_rd;
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TXA-1:0]] <= io_din[7:0];
        if (rx_push) rx_mem[rx_wp[RXA-1:0]] <= uart_rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
            io_dout <= 32'h0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + txp_t'(1);
            if (tx_pop)  tx_rp <= tx_rp + txp_t'(1);
            if (rx_push) rx_wp <= rx_wp + rxp_t'(1);
            if (rx_pop)  rx_rp <= rx_rp + rxp_t'(1);
            // A same-cycle overflow beats the read-clear.
            tx_ovf <= (tx_ovf && !stat_rd) || tx_drop;
            rx_ovf <= (rx_ovf && !stat_rd) || rx_drop;
            if (rd) io_dout <= rd_val;
        end
    end

`ifdef RISCV_IO_COUNTERS_EN
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;
    logic             cnt_clr;

    assign cnt_clr = wr && (off == 8'h18);
    assign cyc_rd  = 32'(cyc_cnt);
    assign ins_rd  = 32'(ins_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            ins_cnt <= ins_cnt + CNT_W'(inst_retired);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    logic             unused_ret;

    assign cyc_rd     = 32'h0;
    assign ins_rd     = 32'h0;
    assign unused_cnt = '0;
    assign unused_ret = inst_retired;
`endif

    logic unused_bits;
    assign unused_bits = ^{io_addr[30:8], io_din[31:8]};

endmodule

// File: tb/tb_riscv_io_ctrl.sv
// Bench for riscv_io_ctrl: queue-based model checked every cycle plus directed literal checks.
module tb_riscv_io_ctrl;
    localparam int RXD = 8;
    localparam int TXD = 8;

    logic        clk, rst, stall;
    logic [31:0] io_addr, io_din, io_dout;
    logic        io_re, inst_retired;
    logic [3:0]  io_we;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

    riscv_io_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .io_addr(io_addr), .io_re(io_re), .io_we(io_we), .io_din(io_din), .io_dout(io_dout),
        .inst_retired(inst_retired),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_rovf, m_tovf, m_acc, m_rd, m_wr, m_tpop, m_rpop;
    logic [7:0]  m_off;
    logic [31:0] m_cyc, m_ins, m_dout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            txq.delete();
            rxq.delete();
            m_rovf = 1'b0;
            m_tovf = 1'b0;
            m_cyc  = 0;
            m_ins  = 0;
            m_dout = 0;
        end else begin
            m_acc  = io_addr[31] && !stall;
            m_off  = io_addr[7:0];
            m_rd   = m_acc && io_re;
            m_wr   = m_acc && (io_we != 0);
            m_tpop = (txq.size() != 0) && uart_tx_ready;
            m_rpop = m_rd && (m_off == 8'h04) && (rxq.size() != 0);
            if (m_rd) begin
                case (m_off)
                    8'h00: m_dout = {28'b0, m_rovf, m_tovf, rxq.size() != 0, txq.size() < TXD};
                    8'h04: m_dout = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
`ifdef RISCV_IO_COUNTERS_EN
                    8'h10: m_dout = m_cyc;
                    8'h14: m_dout = m_ins;
`endif
                    default: m_dout = 32'h0;
                endcase
                if (m_off == 8'h00) begin
                    m_rovf = 1'b0;
                    m_tovf = 1'b0;
                end
            end
            if (m_tpop) void'(txq.pop_front());
            if (m_rpop) void'(rxq.pop_front());
            if (m_wr && m_off == 8'h08) begin
                if (txq.size() < TXD) txq.push_back(io_din[7:0]);
                else m_tovf = 1'b1;
            end
            if (uart_rx_valid) begin
                if (rxq.size() < RXD) rxq.push_back(uart_rx_data);
                else m_rovf = 1'b1;
            end
            if (m_wr && m_off == 8'h18) begin
                m_cyc = 0;
                m_ins = 0;
            end else begin
                m_cyc = m_cyc + 1;
                m_ins = m_ins + 32'(inst_retired);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("tx_valid", uart_tx_valid, txq.size() != 0);
            check("tx_data", uart_tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
            check("rx_ready", uart_rx_ready, 1);
            check("io_dout", io_dout, m_dout);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic bus(input logic [31:0] a, input logic re, input logic [3:0] we, input logic [7:0] d);
        io_addr = a;
        io_re   = re;
        io_we   = we;
        io_din  = {24'h5A5A5A, d};
        @(negedge clk);
        io_addr = 32'h0;
        io_re   = 1'b0;
        io_we   = 4'h0;
    endtask

    task automatic rd(input logic [7:0] o);
        bus(32'h8000_0000 | 32'(o), 1'b1, 4'h0, 8'h00);
    endtask

    task automatic wr(input logic [7:0] o, input logic [7:0] d);
        bus(32'h8000_0000 | 32'(o), 1'b0, 4'hF, d);
    endtask

    task automatic rx_push(input logic [7:0] d);
        uart_rx_valid = 1'b1;
        uart_rx_data  = d;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    logic [7:0] drained[$];
    task automatic drain();
        drained.delete();
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx_valid) drained.push_back(uart_tx_data);
            @(negedge clk);
        end
        uart_tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; io_addr = 0; io_re = 0; io_we = 0; io_din = 0;
        inst_retired = 0; uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_dout", io_dout, 32'h0);
        check("rst_tx_valid", uart_tx_valid, 0);
        check("rst_tx_data", uart_tx_data, 0);
        check("rst_rx_ready", uart_rx_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rd(8'h00);
        check("reset_status", io_dout, 32'h1);

        // TX fill, overflow and in-order drain
        for (int i = 0; i < 8; i++) wr(8'h08, 8'(8'h41 + i));
        rd(8'h00);
        check("tx_full_status", io_dout, 32'h0);
        wr(8'h08, 8'h49);
        rd(8'h00);
        check("tx_ovf_status", io_dout, 32'h4);
        drain();
        check("tx_drain_count", drained.size(), 8);
        for (int i = 0; i < drained.size(); i++) check("tx_drain_byte", drained[i], 8'(8'h41 + i));
        rd(8'h00);
        check("tx_ovf_cleared", io_dout, 32'h1);

        // RX basic
        rx_push(8'h55);
        rx_push(8'hAA);
        rd(8'h04); check("rx_first", io_dout, 32'h55);
        rd(8'h04); check("rx_second", io_dout, 32'hAA);
        rd(8'h04); check("rx_empty_read", io_dout, 32'h0);
        rd(8'h00); check("rx_empty_status", io_dout, 32'h1);

        // RX overflow with TX full
        for (int i = 0; i < 8; i++) wr(8'h08, 8'(8'h60 + i));
        for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i));
        rd(8'h00); check("rx_ovf_status", io_dout, 32'hA);
        rd(8'h00); check("rx_ovf_cleared", io_dout, 32'h2);

        // full TX: push and pop in the same cycle
        uart_tx_ready = 1'b1;
        wr(8'h08, 8'h99);
        uart_tx_ready = 1'b0;
        rd(8'h00); check("tx_pushpop_status", io_dout, 32'h2);
        drain();
        check("tx_pp_count", drained.size(), 8);
        if (drained.size() == 8) begin
            check("tx_pp_first", drained[0], 8'h61);
            check("tx_pp_last", drained[7], 8'h99);
        end

        // full RX: push and pop in the same cycle
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        rd(8'h04);
        uart_rx_valid = 1'b0;
        check("rx_pushpop_head", io_dout, 32'h10);
        rd(8'h00); check("rx_pushpop_status", io_dout, 32'h3);
        for (int i = 0; i < 7; i++) begin
            rd(8'h04);
            check("rx_pp_byte", io_dout, 32'(8'h11 + i));
        end
        rd(8'h04); check("rx_pp_last", io_dout, 32'h77);

        // stall, non-I/O address and unmapped offset
        stall = 1'b1;
        wr(8'h08, 8'h5A);
        rd(8'h00);
        stall = 1'b0;
        check("stall_hold", io_dout, 32'h77);
        check("stall_no_push", uart_tx_valid, 0);
        bus(32'h0000_0008, 1'b0, 4'h1, 8'h5B);
        check("nonio_no_push", uart_tx_valid, 0);
        rd(8'h0C); check("unmapped_read", io_dout, 32'h0);

        // reset mid-transfer discards FIFO contents
        wr(8'h08, 8'h31);
        wr(8'h08, 8'h32);
        rx_push(8'h33);
        check("pre_reset_valid", uart_tx_valid, 1);
        #2 rst = 1'b0;
        #1 check("mid_reset_valid", uart_tx_valid, 0);
        check("mid_reset_data", uart_tx_data, 0);
        check("mid_reset_dout", io_dout, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rd(8'h00); check("post_reset_status", io_dout, 32'h1);

        // counters
        wr(8'h18, 8'h00);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i < 40);
            @(negedge clk);
        end
        inst_retired = 1'b0;
        rd(8'h10);
`ifdef RISCV_IO_COUNTERS_EN
        check("cycle_count", io_dout, 32'd100);
`else
        check("cycle_count_off", io_dout, 32'd0);
`endif
        rd(8'h14);
`ifdef RISCV_IO_COUNTERS_EN
        check("inst_count", io_dout, 32'd40);
`else
        check("inst_count_off", io_dout, 32'd0);
`endif
        wr(8'h18, 8'h00);
        rd(8'h10);
        check("cycle_after_clear", io_dout, 32'd0);
        rd(8'h14);
        check("inst_after_clear", io_dout, 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
